// File: rtl/mobilenet_dataflow_pkg.sv
// Shared defaults and FSM encoding for the window-forming dataflow path.
package mobilenet_dataflow_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_MAX_WIDTH  = 224;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_ROW_WIDTH  = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2
   } lb_state_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM: one write port, one registered read-first port.
module line_ram #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 224,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Same-edge read sees the pre-write word (read-first); output holds when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/line_buffer_3row.sv
// Raster pixel stream in, vertical 3-tap (rows r-2, r-1, r) out with frame geometry tracking.
// state     | meaning
// ST_IDLE   | waiting for a valid sof pixel with legal geometry
// ST_FILL   | rows 0 and 1 being stored, no taps emitted
// ST_STREAM | rows 2..H-1, one tap triple per accepted pixel
module line_buffer_3row
   import mobilenet_dataflow_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_WIDTH  = DEF_MAX_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ROW_WIDTH  = DEF_ROW_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cfg_width,
   input  logic [ROW_WIDTH-1:0]  cfg_height,
   input  logic [DATA_WIDTH-1:0] pix_in,
   input  logic                  pix_valid,
   input  logic                  pix_sof,
   output logic [DATA_WIDTH-1:0] row0,
   output logic [DATA_WIDTH-1:0] row1,
   output logic [DATA_WIDTH-1:0] row2,
   output logic                  valid_out,
   output logic                  eol_out,
   output logic                  eof_out,
   output logic                  frame_done,
   output logic                  err_cfg,
   output logic                  err_sof
);

   localparam logic [ADDR_WIDTH:0] MAX_W = (ADDR_WIDTH+1)'(MAX_WIDTH);

   lb_state_t             state, state_nxt;
   logic [ADDR_WIDTH-1:0] col, col_nxt, w_q, w_nxt, acc_col;
   logic [ROW_WIDTH-1:0]  row, row_nxt, h_q, h_nxt, acc_row;
   logic                  acc, cfg_ok, is_eol, is_eof, tap_en;
   logic                  err_cfg_nxt, err_sof_nxt, sel_q;
   logic [DATA_WIDTH-1:0] bank0_rd, bank1_rd;

   assign cfg_ok = (cfg_width >= ADDR_WIDTH'(3)) && ({1'b0, cfg_width} <= MAX_W)
                   && (cfg_height >= ROW_WIDTH'(3));

   always_comb begin
      state_nxt   = state;
      col_nxt     = col;
      row_nxt     = row;
      w_nxt       = w_q;
      h_nxt       = h_q;
      acc         = 1'b0;
      acc_col     = col;
      acc_row     = row;
      err_cfg_nxt = 1'b0;
      err_sof_nxt = 1'b0;
      if (pix_valid && pix_sof) begin
         err_sof_nxt = (state != ST_IDLE);
         if (cfg_ok) begin
            acc       = 1'b1;
            acc_col   = '0;
            acc_row   = '0;
            w_nxt     = cfg_width;
            h_nxt     = cfg_height;
            state_nxt = ST_FILL;
         end else begin
            err_cfg_nxt = 1'b1;
            state_nxt   = ST_IDLE;
            col_nxt     = '0;
            row_nxt     = '0;
         end
      end else if (pix_valid && state != ST_IDLE) begin
         acc = 1'b1;
      end
      is_eol = acc && (acc_col == w_nxt - ADDR_WIDTH'(1));
      is_eof = is_eol && (acc_row == h_nxt - ROW_WIDTH'(1));
      if (acc) begin
         col_nxt = acc_col + ADDR_WIDTH'(1);
         row_nxt = acc_row;
         if (is_eof) begin
            state_nxt = ST_IDLE;
            col_nxt   = '0;
            row_nxt   = '0;
         end else if (is_eol) begin
            col_nxt = '0;
            row_nxt = acc_row + ROW_WIDTH'(1);
            if (acc_row == ROW_WIDTH'(1)) state_nxt = ST_STREAM;
         end
      end
   end

   assign tap_en = acc && (acc_row >= ROW_WIDTH'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         col        <= '0;
         row        <= '0;
         w_q        <= '0;
         h_q        <= '0;
         row2       <= '0;
         sel_q      <= 1'b0;
         valid_out  <= 1'b0;
         eol_out    <= 1'b0;
         eof_out    <= 1'b0;
         frame_done <= 1'b0;
         err_cfg    <= 1'b0;
         err_sof    <= 1'b0;
      end else begin
         state      <= state_nxt;
         col        <= col_nxt;
         row        <= row_nxt;
         w_q        <= w_nxt;
         h_q        <= h_nxt;
         valid_out  <= tap_en;
         eol_out    <= tap_en && is_eol;
         eof_out    <= tap_en && is_eof;
         frame_done <= tap_en && is_eof;
         err_cfg    <= err_cfg_nxt;
         err_sof    <= err_sof_nxt;
         if (tap_en) begin
            row2  <= pix_in;
            sel_q <= acc_row[0];
         end
      end
   end

   // Ping-pong banks: row r overwrites the bank holding row r-2, which shares its parity.
   // Equivalent to shifting lb1 into lb0 without a read-modify-write.
   line_ram #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (acc && !acc_row[0]),
      .wr_addr (acc_col),
      .wr_data (pix_in),
      .rd_en   (tap_en),
      .rd_addr (acc_col),
      .rd_data (bank0_rd)
   );

   line_ram #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (acc && acc_row[0]),
      .wr_addr (acc_col),
      .wr_data (pix_in),
      .rd_en   (tap_en),
      .rd_addr (acc_col),
      .rd_data (bank1_rd)
   );

   assign row0 = sel_q ? bank1_rd : bank0_rd;
   assign row1 = sel_q ? bank0_rd : bank1_rd;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed vector bench for line_buffer_3row: frames, gaps, bad config, restart and reset.
module tb_line_buffer_3row;

   typedef struct {
      logic        pv;
      logic        sof;
      logic [15:0] pix;
      logic [7:0]  cw;
      logic [7:0]  ch;
      logic        e_valid;
      logic        e_eol;
      logic        e_eof;
      logic        e_done;
      logic        e_errc;
      logic        e_errs;
      logic [15:0] e_r0;
      logic [15:0] e_r1;
      logic [15:0] e_r2;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  cfg_width = '0;
   logic [7:0]  cfg_height = '0;
   logic [15:0] pix_in = '0;
   logic        pix_valid = 1'b0;
   logic        pix_sof = 1'b0;
   logic [15:0] row0, row1, row2;
   logic        valid_out, eol_out, eof_out, frame_done, err_cfg, err_sof;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   line_buffer_3row dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_sof    (pix_sof),
      .row0       (row0),
      .row1       (row1),
      .row2       (row2),
      .valid_out  (valid_out),
      .eol_out    (eol_out),
      .eof_out    (eof_out),
      .frame_done (frame_done),
      .err_cfg    (err_cfg),
      .err_sof    (err_sof)
   );

   function automatic vec_t blank(input logic pv, input logic sof);
      vec_t v;
      v.pv = pv; v.sof = sof; v.pix = 16'($urandom_range(0, 65535));
      v.cw = 8'($urandom_range(0, 255)); v.ch = 8'($urandom_range(0, 255));
      v.e_valid = 0; v.e_eol = 0; v.e_eof = 0; v.e_done = 0; v.e_errc = 0; v.e_errs = 0;
      v.e_r0 = '0; v.e_r1 = '0; v.e_r2 = '0;
      return v;
   endfunction

   // Idle cycles: pix_valid low, sof and cfg junk must be ignored.
   function automatic void push_idle(input int n);
      for (int i = 0; i < n; i++) vecs.push_back(blank(1'b0, 1'($urandom_range(0, 1))));
   endfunction

   // Stray non-sof pixels while idle: nothing should come out.
   function automatic void push_stray(input int n);
      for (int i = 0; i < n; i++) vecs.push_back(blank(1'b1, 1'b0));
   endfunction

   function automatic void push_bad(input logic [7:0] w, input logic [7:0] h);
      vec_t v;
      v = blank(1'b1, 1'b1);
      v.cw = w; v.ch = h; v.e_errc = 1'b1;
      vecs.push_back(v);
      push_stray(2);
   endfunction

   // Pixel k of a WxH frame carries base+k, so the tap above it is base+k-W.
   function automatic void add_frame(input int w, input int h, input int base, input int npix,
                                     input int gap_max, input logic errs_first);
      vec_t v;
      int   r, c;
      for (int k = 0; k < npix; k++) begin
         if (k > 0 && gap_max > 0 && $urandom_range(0, 2) == 0) push_idle($urandom_range(1, gap_max));
         r = k / w;
         c = k % w;
         v = blank(1'b1, k == 0);
         v.pix = 16'(base + k);
         if (k == 0) begin
            v.cw = 8'(w); v.ch = 8'(h); v.e_errs = errs_first;
         end
         if (r >= 2) begin
            v.e_valid = 1'b1;
            v.e_r0 = 16'(base + k - 2 * w);
            v.e_r1 = 16'(base + k - w);
            v.e_r2 = 16'(base + k);
            v.e_eol = (c == w - 1);
            v.e_eof = (c == w - 1) && (r == h - 1);
            v.e_done = v.e_eof;
         end
         vecs.push_back(v);
      end
   endfunction

   task automatic run_vecs(input string tag);
      logic [5:0] got, exp;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         pix_valid = vecs[i].pv; pix_sof = vecs[i].sof; pix_in = vecs[i].pix;
         cfg_width = vecs[i].cw; cfg_height = vecs[i].ch;
         @(posedge clk);
         #1;
         got = {valid_out, eol_out, eof_out, frame_done, err_cfg, err_sof};
         exp = {vecs[i].e_valid, vecs[i].e_eol, vecs[i].e_eof, vecs[i].e_done,
                vecs[i].e_errc, vecs[i].e_errs};
         n_tests++;
         if (got != exp || (vecs[i].e_valid &&
             {row0, row1, row2} != {vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_r2})) begin
            n_fail++;
            $display("FAIL %s vec%0d flags(v,eol,eof,done,ec,es) got %b exp %b taps got %0d/%0d/%0d exp %0d/%0d/%0d",
                     tag, i, got, exp, row0, row1, row2, vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_r2);
         end
      end
      vecs.delete();
      @(negedge clk);
      pix_valid = 1'b0; pix_sof = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      n_tests++;
      if ({row0, row1, row2, valid_out, eol_out, eof_out, frame_done, err_cfg, err_sof} != '0) begin
         n_fail++;
         $display("FAIL %s outputs not zero: taps %0d/%0d/%0d flags %b%b%b%b%b%b", tag, row0, row1, row2,
                  valid_out, eol_out, eof_out, frame_done, err_cfg, err_sof);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Stray pixels before any sof, then the reference 4x4 frame 0..15.
      push_stray(3);
      add_frame(4, 4, 0, 16, 0, 1'b0);
      push_idle(2);
      run_vecs("frame4x4");

      // Hand check of the first window of a fresh 4x4 frame.
      add_frame(4, 4, 0, 9, 0, 1'b0);
      run_vecs("first_window_prep");
      n_tests++;
      if (!(row0 == 16'd0 && row1 == 16'd4 && row2 == 16'd8)) begin
         n_fail++;
         $display("FAIL first_window taps got %0d/%0d/%0d exp 0/4/8", row0, row1, row2);
      end
      // Taps must hold through an idle cycle; the mid-frame sof restart covers the rest.
      @(posedge clk); #1;
      n_tests++;
      if (!(valid_out == 1'b0 && row0 == 16'd0 && row1 == 16'd4 && row2 == 16'd8)) begin
         n_fail++;
         $display("FAIL tap_hold got v=%b taps %0d/%0d/%0d exp v=0 0/4/8", valid_out, row0, row1, row2);
      end
      add_frame(4, 4, 100, 16, 0, 1'b1);
      run_vecs("restart_after_hold");

      add_frame(4, 4, 0, 16, 3, 1'b0);
      push_idle(2);
      run_vecs("frame4x4_gaps");

      push_bad(8'd2, 8'd4);
      push_bad(8'd4, 8'd2);
      push_bad(8'd225, 8'd4);
      run_vecs("bad_cfg");

      add_frame(4, 4, 0, 6, 0, 1'b0);
      add_frame(4, 4, 50, 16, 0, 1'b1);
      push_idle(1);
      run_vecs("sof_restart");

      add_frame(224, 3, 1000, 672, 0, 1'b0);
      add_frame(5, 4, 5000, 20, 2, 1'b0);
      push_idle(1);
      run_vecs("b2b_frames");

      // Reset in the middle of a frame right after a valid beat.
      add_frame(4, 4, 200, 10, 0, 1'b0);
      run_vecs("pre_reset");
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_mid_frame");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push_stray(5);
      add_frame(4, 4, 300, 16, 0, 1'b0);
      run_vecs("post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
